// File: rtl/snake_pkg.sv
// Shared definitions for the score display path.
// Holds the conversion FSM state encoding, the seven-segment lookup table and
// the blank pattern, plus the double-dabble nibble adjust helper.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  // Active-high segments, bit6..bit0 = g..a. Entry n is the glyph for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Double-dabble pre-shift correction: any nibble >= 5 gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return adj;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Purpose: map one BCD digit to its seven-segment glyph; codes 10-15 are blank.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
// Ports: i_digit - 4-bit digit code; o_seg - segments, bit6..bit0 = g..a.
import snake_pkg::*;

module seg7_decoder (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_digit <= 4'd9) begin
      o_seg = SEG_TABLE[i_digit];
    end
  end

endmodule

// File: rtl/score_display.sv
// Purpose: convert a 7-bit score to three seven-segment digits with leading-zero
//          blanking and a game-over blink.
// Latency: new digits visible 8 cycles after the start edge; busy high meanwhile.
// Backpressure: none; score changes while busy are not queued, only the latest
//          value is converted once the FSM is idle again.
// Ports: clk, rst (sync, active-high); dispScore - binary score 0..127;
//        isGameComplete - blink enable; ss0/ss1/ss2 - ones/tens/hundreds
//        segments (g..a); busy - conversion in progress.
import snake_pkg::*;

module score_display #(
  parameter int BLINK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] dispScore,
  input  logic       isGameComplete,
  output logic [6:0] ss0,
  output logic [6:0] ss1,
  output logic [6:0] ss2,
  output logic       busy
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t      r_state;
  logic [6:0]  r_last;
  logic [6:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_iter;
  logic [3:0]  r_dig0;
  logic [3:0]  r_dig1;
  logic [3:0]  r_dig2;
  logic [CNT_W-1:0] r_blink_cnt;
  logic        r_blink_phase;

  logic [11:0] w_bcd_adj;
  logic [6:0]  w_seg0;
  logic [6:0]  w_seg1;
  logic [6:0]  w_seg2;

  assign w_bcd_adj = dd_adjust(r_bcd);

  // Conversion FSM. The iteration counter reaching 6 means this edge performs
  // the 7th shift, after which all binary bits have moved into the BCD field.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 7'd0;
      r_bin   <= 7'd0;
      r_bcd   <= 12'd0;
      r_iter  <= 3'd0;
      r_dig0  <= 4'd0;
      r_dig1  <= 4'd0;
      r_dig2  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dispScore != r_last) begin
            r_bin   <= dispScore;
            r_last  <= dispScore;
            r_iter  <= 3'd0;
            r_bcd   <= 12'd0;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          r_bcd  <= {w_bcd_adj[10:0], r_bin[6]};
          r_bin  <= {r_bin[5:0], 1'b0};
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd6) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_dig0  <= r_bcd[3:0];
          r_dig1  <= r_bcd[7:4];
          r_dig2  <= r_bcd[11:8];
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Blink timer: free-runs only while the game is over; otherwise held in the
  // visible phase so the digits show steadily.
  always_ff @(posedge clk) begin
    if (rst || !isGameComplete) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CNT_W'(1);
    end
  end

  seg7_decoder u_dec0 (.i_digit(r_dig0), .o_seg(w_seg0));
  seg7_decoder u_dec1 (.i_digit(r_dig1), .o_seg(w_seg1));
  seg7_decoder u_dec2 (.i_digit(r_dig2), .o_seg(w_seg2));

  // Leading-zero blanking: tens blanks only when hundreds is also zero; ones
  // always shows. The dark blink phase overrides everything.
  assign ss2  = (!r_blink_phase || r_dig2 == 4'd0) ? SEG_BLANK : w_seg2;
  assign ss1  = (!r_blink_phase || (r_dig2 == 4'd0 && r_dig1 == 4'd0)) ? SEG_BLANK : w_seg1;
  assign ss0  = (!r_blink_phase) ? SEG_BLANK : w_seg0;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  logic       clk;
  logic       rst;
  logic [6:0] dispScore;
  logic       isGameComplete;
  logic [6:0] ss0;
  logic [6:0] ss1;
  logic [6:0] ss2;
  logic       busy;

  int checks;
  int failures;

  score_display #(.BLINK_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispScore      (dispScore),
    .isGameComplete (isGameComplete),
    .ss0            (ss0),
    .ss1            (ss1),
    .ss2            (ss2),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_ss2"}, ss2, e2);
    check({tag, "_ss1"}, ss1, e1);
    check({tag, "_ss0"}, ss0, e0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    dispScore = 7'd0;
    isGameComplete = 1'b0;
    tick(2);

    // Reset state
    check_disp("reset", 7'h00, 7'h00, 7'h3F);
    check("reset_busy", {6'd0, busy}, 7'd0);
    rst = 1'b0;
    tick(1);
    check("idle_busy", {6'd0, busy}, 7'd0);

    // 0 -> 7: busy from E0 through E7, digits appear after E8
    dispScore = 7'd7;
    tick(1);                                   // E0
    check("s7_busy_e0", {6'd0, busy}, 7'd1);
    tick(7);                                   // E7
    check("s7_busy_e7", {6'd0, busy}, 7'd1);
    check("s7_old_ss0_e7", ss0, 7'h3F);
    tick(1);                                   // E8
    check("s7_busy_e8", {6'd0, busy}, 7'd0);
    check_disp("s7", 7'h00, 7'h00, 7'h07);

    // 100 and 127
    dispScore = 7'd100;
    tick(9);
    check_disp("s100", 7'h06, 7'h3F, 7'h3F);
    dispScore = 7'd127;
    tick(9);
    check_disp("s127", 7'h06, 7'h5B, 7'h07);

    // 1 -> 2 -> 3 on consecutive cycles: 1 converts, 2 dropped, 3 converts
    dispScore = 7'd1;
    tick(1);                                   // E0 for value 1
    dispScore = 7'd2;
    tick(1);
    dispScore = 7'd3;
    tick(7);                                   // E8 for value 1
    check("seq_busy_mid", {6'd0, busy}, 7'd0);
    check_disp("seq_first", 7'h00, 7'h00, 7'h06);
    tick(1);                                   // E0 for value 3
    check("seq_busy_restart", {6'd0, busy}, 7'd1);
    tick(8);
    check("seq_busy_end", {6'd0, busy}, 7'd0);
    check_disp("seq_final", 7'h00, 7'h00, 7'h4F);
    tick(5);
    check("seq_no_third", {6'd0, busy}, 7'd0);

    // Reset at E3 of a conversion aborts it
    dispScore = 7'd55;
    tick(3);                                   // E0..E2
    check("abort_busy_pre", {6'd0, busy}, 7'd1);
    rst = 1'b1;
    tick(1);                                   // E3 with reset
    check("abort_busy", {6'd0, busy}, 7'd0);
    check_disp("abort", 7'h00, 7'h00, 7'h3F);
    rst = 1'b0;
    dispScore = 7'd0;
    tick(10);
    check("abort_stale_busy", {6'd0, busy}, 7'd0);
    check_disp("abort_stale", 7'h00, 7'h00, 7'h3F);

    // Blink with BLINK_DIV=4 and score 42
    dispScore = 7'd42;
    tick(9);
    check_disp("s42", 7'h00, 7'h66, 7'h5B);
    isGameComplete = 1'b1;
    tick(3);
    check_disp("blink_vis_a", 7'h00, 7'h66, 7'h5B);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_disp("blink_dark_a", 7'h00, 7'h00, 7'h00);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_disp("blink_vis_b", 7'h00, 7'h66, 7'h5B);
    end
    tick(1);
    check_disp("blink_dark_b", 7'h00, 7'h00, 7'h00);
    isGameComplete = 1'b0;
    tick(1);
    check_disp("blink_off", 7'h00, 7'h66, 7'h5B);
    tick(6);
    check_disp("blink_steady", 7'h00, 7'h66, 7'h5B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
